// File: rtl/gtx_link_ctrl.sv
// gtx_link_ctrl: bring-up and monitoring controller for one GTX lane.
// It waits for QPLL lock, pulses the GT resets, waits for reset-done and
// aligns on K28.5 commas. It then sends an incrementing counter and checks
// the received counter stream.
module gtx_link_ctrl #(
  parameter int          LOCK_TIMEOUT = 100000,
  parameter int          RST_CYCLES   = 16,
  parameter int          ALIGN_WORDS  = 64,
  parameter logic [15:0] ERR_LIMIT    = 16'd1000
) (
  input  logic        sysclk_in,
  input  logic        soft_reset_in,
  input  logic        start_in,
  input  logic        qplllock_in,
  input  logic        txresetdone_in,
  input  logic        rxresetdone_in,
  output logic        gttxreset_out,
  output logic        gtrxreset_out,
  output logic        txuserrdy_out,
  output logic        rxuserrdy_out,
  output logic [31:0] txdata_out,
  output logic [3:0]  txcharisk_out,
  input  logic [31:0] rxdata_in,
  input  logic [3:0]  rxcharisk_in,
  output logic        link_up_out,
  output logic [2:0]  state_out,
  output logic [15:0] err_count_out,
  output logic [31:0] word_count_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RESET_GT  = 3'd2,
    WAIT_DONE = 3'd3,
    ALIGN     = 3'd4,
    DATA      = 3'd5,
    FAIL      = 3'd6
  } state_e;

  localparam logic [31:0] COMMA_WORD = 32'h0000_00BC;
  localparam logic [3:0]  COMMA_K    = 4'b0001;
  localparam logic [31:0] TMO_LAST   = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] ALIGN_LAST = 32'(ALIGN_WORDS - 1);

  state_e      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;            // per-state cycle counter (timeouts, reset pulse)
  logic [31:0] align_cnt_q, align_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] expected_q, expected_d;
  logic        seeded_q, seeded_d;
  logic [31:0] txdata_q, txdata_d;
  logic [3:0]  txk_q, txk_d;
  logic        link_up_q, link_up_d;

  logic is_comma;
  logic tmo_hit;
  logic align_done;
  logic data_active;
  logic bringup_entry;

  assign is_comma   = (rxdata_in == COMMA_WORD) && (rxcharisk_in == COMMA_K);
  assign tmo_hit    = (tmr_q == TMO_LAST);
  assign align_done = is_comma && (align_cnt_q == ALIGN_LAST);

  // State register; soft reset overrides every transition, start_in included.
  always_ff @(posedge sysclk_in) begin
    // NOTE: flops use non-blocking assignments so every register updates from the same pre-edge values.
    if (soft_reset_in) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Next-state logic; loss of QPLL lock outranks every other exit once the GT is in reset or running.
  always_comb begin
    // NOTE: state_d gets a default first so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_in) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (qplllock_in)  state_d = RESET_GT;
        else if (tmo_hit) state_d = FAIL;
      end
      RESET_GT: begin
        if (!qplllock_in)           state_d = FAIL;
        else if (tmr_q == RST_LAST) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!qplllock_in)                          state_d = FAIL;
        else if (txresetdone_in && rxresetdone_in) state_d = ALIGN;
        else if (tmo_hit)                          state_d = FAIL;
      end
      ALIGN: begin
        if (!qplllock_in)    state_d = FAIL;
        else if (align_done) state_d = DATA;
        else if (tmo_hit)    state_d = FAIL;
      end
      DATA: begin
        if (!qplllock_in)                state_d = FAIL;
        else if (err_cnt_q >= ERR_LIMIT) state_d = FAIL;
      end
      FAIL: begin
        if (start_in) state_d = WAIT_LOCK;
      end
      default: state_d = IDLE;
    endcase
  end

  // GT control outputs decoded directly from the current state.
  always_comb begin
    gttxreset_out = (state_q == RESET_GT);
    gtrxreset_out = (state_q == RESET_GT);
    txuserrdy_out = (state_q == WAIT_DONE) || (state_q == ALIGN) || (state_q == DATA);
    rxuserrdy_out = (state_q == WAIT_DONE) || (state_q == ALIGN) || (state_q == DATA);
    state_out     = state_q;
  end

  assign bringup_entry = (state_d == WAIT_LOCK) && (state_q != WAIT_LOCK);
  // A DATA cycle with lock already lost is treated as link-down: nothing is counted or compared.
  assign data_active   = (state_q == DATA) && qplllock_in;

  // Datapath next values: timers, alignment count, RX checker and TX word.
  always_comb begin
    tmr_d       = 32'd0;
    align_cnt_d = 32'd0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    expected_d  = expected_q;
    seeded_d    = (state_q == DATA) ? seeded_q : 1'b0;
    txdata_d    = 32'd0;
    txk_d       = 4'd0;
    link_up_d   = (state_q == DATA);

    // The timer restarts on every state change and runs only in the timed states.
    if (state_d == state_q) begin
      case (state_q)
        WAIT_LOCK, RESET_GT, WAIT_DONE, ALIGN: tmr_d = tmr_q + 32'd1;
        default:                               tmr_d = 32'd0;
      endcase
    end

    if (state_q == ALIGN && is_comma) align_cnt_d = align_cnt_q + 32'd1;

    if (bringup_entry) begin
      err_cnt_d  = 16'd0;
      word_cnt_d = 32'd0;
      expected_d = 32'd0;
    end else if (data_active && rxcharisk_in == 4'd0) begin
      if (!seeded_q) begin
        // First data word only establishes where the far end's counter is.
        seeded_d   = 1'b1;
        expected_d = rxdata_in + 32'd1;
      end else begin
        word_cnt_d = word_cnt_q + 32'd1;
        if (rxdata_in != expected_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          expected_d = rxdata_in + 32'd1;
        end else begin
          expected_d = expected_q + 32'd1;
        end
      end
    end

    // TX word is registered against the next state so it lines up with state_out.
    case (state_d)
      ALIGN: begin
        txdata_d = COMMA_WORD;
        txk_d    = COMMA_K;
      end
      DATA: begin
        txdata_d = (state_q == DATA) ? txdata_q + 32'd1 : 32'd0;
        txk_d    = 4'd0;
      end
      default: begin
        txdata_d = 32'd0;
        txk_d    = 4'd0;
      end
    endcase
  end

  // Datapath registers, all cleared by soft reset.
  always_ff @(posedge sysclk_in) begin
    if (soft_reset_in) begin
      tmr_q       <= 32'd0;
      align_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
      word_cnt_q  <= 32'd0;
      expected_q  <= 32'd0;
      seeded_q    <= 1'b0;
      txdata_q    <= 32'd0;
      txk_q       <= 4'd0;
      link_up_q   <= 1'b0;
    end else begin
      tmr_q       <= tmr_d;
      align_cnt_q <= align_cnt_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      expected_q  <= expected_d;
      seeded_q    <= seeded_d;
      txdata_q    <= txdata_d;
      txk_q       <= txk_d;
      link_up_q   <= link_up_d;
    end
  end

  assign txdata_out     = txdata_q;
  assign txcharisk_out  = txk_q;
  assign link_up_out    = link_up_q;
  assign err_count_out  = err_cnt_q;
  assign word_count_out = word_cnt_q;

endmodule

// File: tb/tb_gtx_link_ctrl.sv
// Self-checking bench for gtx_link_ctrl: directed bring-up scenarios plus
// randomized RX data streams scored against a rule-level checker model.
`timescale 1ns/1ps
module tb_gtx_link_ctrl;

  localparam int          LT = 1000;
  localparam int          RC = 16;
  localparam int          AW = 64;
  localparam logic [15:0] EL = 16'd20;

  localparam logic [31:0] S_IDLE = 0, S_WL = 1, S_RST = 2, S_WD = 3,
                          S_ALIGN = 4, S_DATA = 5, S_FAIL = 6;

  logic        clk = 1'b0;
  logic        soft_reset, start, lock, txdone, rxdone;
  logic        gttxreset, gtrxreset, txuserrdy, rxuserrdy, link_up;
  logic [31:0] txdata, rxdata, word_count;
  logic [3:0]  txk, rxk;
  logic [2:0]  state;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_err = 0;

  // Checker reference model state.
  bit          m_seeded;
  logic [31:0] m_exp;
  int          m_err;
  logic [31:0] m_words;

  gtx_link_ctrl #(
    .LOCK_TIMEOUT(LT), .RST_CYCLES(RC), .ALIGN_WORDS(AW), .ERR_LIMIT(EL)
  ) dut (
    .sysclk_in(clk), .soft_reset_in(soft_reset), .start_in(start),
    .qplllock_in(lock), .txresetdone_in(txdone), .rxresetdone_in(rxdone),
    .gttxreset_out(gttxreset), .gtrxreset_out(gtrxreset),
    .txuserrdy_out(txuserrdy), .rxuserrdy_out(rxuserrdy),
    .txdata_out(txdata), .txcharisk_out(txk),
    .rxdata_in(rxdata), .rxcharisk_in(rxk),
    .link_up_out(link_up), .state_out(state),
    .err_count_out(err_count), .word_count_out(word_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checker rules: K words ignored, first data word seeds, later words counted and compared.
  task automatic model_word(input logic [31:0] d, input logic [3:0] k);
    if (k != 4'd0) return;
    if (!m_seeded) begin
      m_seeded = 1'b1;
      m_exp    = d + 32'd1;
    end else begin
      m_words = m_words + 32'd1;
      if (d != m_exp) begin
        if (m_err < 65535) m_err++;
        m_exp = d + 32'd1;
      end else begin
        m_exp = m_exp + 32'd1;
      end
    end
  endtask

  task automatic model_clear();
    m_seeded = 1'b0;
    m_exp    = '0;
    m_err    = 0;
    m_words  = '0;
  endtask

  // Start from IDLE/FAIL and run up to the first ALIGN cycle.
  task automatic bring_up(input int done_delay);
    int n;
    start = 1'b1; lock = 1'b1; txdone = 1'b0; rxdone = 1'b0;
    rxdata = '0; rxk = '0;
    step();
    start = 1'b0;
    model_clear();
    check("wl_state", state, S_WL);
    check("wl_err_cleared", err_count, 0);
    check("wl_words_cleared", word_count, 0);
    check("wl_userrdy", txuserrdy, 0);
    step();
    check("rst_rx_pulse", gtrxreset, 1);
    n = 0;
    while (gttxreset === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("gt_reset_width", n, RC);
    check("wd_state", state, S_WD);
    check("wd_userrdy", {txuserrdy, rxuserrdy}, 2'b11);
    check("wd_txdata", txdata, 0);
    repeat (done_delay) step();
    check("wd_held", state, S_WD);
    txdone = 1'b1; rxdone = 1'b1;
    step();
    check("align_state", state, S_ALIGN);
    check("align_txdata", txdata, 32'h0000_00BC);
    check("align_txk", txk, 4'b0001);
  endtask

  // Loop TX back to RX in ALIGN and measure how long alignment takes.
  task automatic align_loopback();
    int n;
    n = 0;
    while (state === S_ALIGN[2:0] && n < LT) begin
      rxdata = txdata; rxk = txk;
      step();
      n++;
    end
    check("align_len", n, AW);
    check("data_state", state, S_DATA);
    check("data_first_tx", txdata, 0);
    check("data_first_txk", txk, 0);
    check("link_up_latency", link_up, 0);
  endtask

  initial begin
    int          n;
    logic [31:0] seq, offset, d, tx_exp;
    logic [3:0]  k;
    bit          fail_next, in_data;

    soft_reset = 1'b1; start = 1'b0; lock = 1'b0; txdone = 1'b0; rxdone = 1'b0;
    rxdata = '0; rxk = '0;
    model_clear();
    step(); step();
    check("rst_state", state, S_IDLE);
    check("rst_outputs", {gttxreset, gtrxreset, txuserrdy, rxuserrdy, link_up}, 0);
    check("rst_txdata", txdata, 0);
    check("rst_counts", {err_count, word_count[15:0]}, 0);
    soft_reset = 1'b0;
    step();
    check("idle_hold", state, S_IDLE);

    // Full bring-up: resetdone 5 cycles after userrdy, looped commas, then DATA.
    bring_up(5);
    align_loopback();
    seq = 32'hFFFF_FFC0 + 32'($urandom_range(63, 0));
    rxdata = seq; rxk = '0;
    model_word(rxdata, rxk);
    step();
    check("link_up", link_up, 1);
    check("data_tx1", txdata, 1);
    check("data_err0", err_count, 0);
    check("seed_not_counted", word_count, 0);

    // Random K insertion with three isolated sequence slips.
    offset = 0;
    tx_exp = 2;
    for (int i = 0; i < 200; i++) begin
      if (i == 40 || i == 90 || i == 150) offset = offset + 32'd1;
      if ($urandom_range(7, 0) == 0) begin
        k = 4'($urandom_range(15, 1));
        d = $urandom;
      end else begin
        seq = seq + 32'd1;
        k = 4'd0;
        d = seq + offset;
      end
      rxdata = d; rxk = k;
      model_word(d, k);
      step();
      check("b_err", err_count, m_err);
      check("b_words", word_count, m_words);
      check("b_txdata", txdata, tx_exp);
      tx_exp = tx_exp + 32'd1;
    end
    check("three_errors", err_count, 3);
    check("b_link_up", link_up, 1);

    // Lock lost in the same cycle as a bad word: FAIL, nothing counted.
    rxdata = seq + 32'd77; rxk = '0; lock = 1'b0;
    step();
    check("lockloss_state", state, S_FAIL);
    check("lockloss_err_frozen", err_count, m_err);
    check("lockloss_words_frozen", word_count, m_words);
    check("fail_txdata", txdata, 0);
    rxdata = $urandom;
    step();
    check("fail_link_down", link_up, 0);
    check("fail_outputs", {gttxreset, gtrxreset, txuserrdy, rxuserrdy}, 0);
    check("fail_err_frozen", err_count, m_err);
    check("fail_state_hold", state, S_FAIL);

    // Alignment broken at count 63 needs a fresh 64 commas; start_in ignored meanwhile.
    bring_up(0);
    start = 1'b1;
    for (int i = 0; i < AW - 1; i++) begin
      rxdata = 32'h0000_00BC; rxk = 4'b0001;
      step();
    end
    check("align_63", state, S_ALIGN);
    rxdata = 32'h0000_00BC; rxk = 4'b0000;
    step();
    check("align_break", state, S_ALIGN);
    for (int i = 0; i < AW - 1; i++) begin
      rxdata = 32'h0000_00BC; rxk = 4'b0001;
      step();
    end
    check("align_63_again", state, S_ALIGN);
    rxdata = 32'h0000_00BC; rxk = 4'b0001;
    step();
    start = 1'b0;
    check("align_64_data", state, S_DATA);

    // Random errors until the error limit forces FAIL.
    seq = $urandom;
    in_data = 1'b1;
    for (int i = 0; i < 400 && in_data; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        k = 4'($urandom_range(15, 1));
        d = $urandom;
      end else begin
        k = 4'd0;
        seq = seq + 32'd1;
        d = ($urandom_range(3, 0) == 0) ? $urandom : seq;
      end
      rxdata = d; rxk = k;
      fail_next = (m_err >= int'(EL));
      model_word(d, k);
      step();
      if (fail_next) in_data = 1'b0;
      check("d_state", state, in_data ? S_DATA : S_FAIL);
      check("d_err", err_count, m_err);
      check("d_words", word_count, m_words);
    end
    check("err_limit_fail", state, S_FAIL);

    // No lock: FAIL after exactly LT cycles in WAIT_LOCK.
    start = 1'b1; lock = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    while (state === S_WL[2:0] && n < LT + 10) begin
      n++;
      step();
    end
    check("lock_timeout_len", n, LT);
    check("lock_timeout_state", state, S_FAIL);

    // Soft reset mid RESET_GT, asserted together with start_in.
    start = 1'b1; lock = 1'b1;
    step();
    start = 1'b0;
    step();
    check("f_rst_state", state, S_RST);
    repeat (5) step();
    check("f_rst_mid", gttxreset, 1);
    soft_reset = 1'b1; start = 1'b1;
    step();
    check("f_reset_idle", state, S_IDLE);
    check("f_gttxreset_low", gttxreset, 0);
    check("f_gtrxreset_low", gtrxreset, 0);
    soft_reset = 1'b0;
    bring_up(2);
    align_loopback();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gtx_link_ctrl.md
GTX_LINK_CTRL -- requirements
Module: gtx_link_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 100000, meaning max cycles waiting for QPLL lock or GT reset-done.
REQ-002 SHALL have parameter RST_CYCLES, default 16, meaning the gttxreset/gtrxreset pulse width in cycles.
REQ-003 SHALL have parameter ALIGN_WORDS, default 64, meaning the consecutive received comma words required to declare alignment.
REQ-004 SHALL have parameter ERR_LIMIT, default 16'd1000, meaning the data error count that forces FAIL.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port sysclk_in, input, 1, meaning the sole clock; all GT user-side ports are synchronous to it.
REQ-007 SHALL have port soft_reset_in, input, 1, meaning the synchronous active-high reset.
REQ-008 SHALL have port start_in, input, 1, meaning start link bring-up (level; sampled in IDLE/FAIL only).
REQ-009 SHALL have ports qplllock_in, txresetdone_in and rxresetdone_in, each input, 1, meaning the GT status inputs.
REQ-010 SHALL have ports gttxreset_out, gtrxreset_out, txuserrdy_out and rxuserrdy_out, each output, 1, meaning the GT reset controls.
REQ-011 SHALL have ports txdata_out (output, 32) and txcharisk_out (output, 4), meaning the TX word and K-flags.
REQ-012 SHALL have ports rxdata_in (input, 32) and rxcharisk_in (input, 4), meaning the RX word and K-flags.
REQ-013 SHALL have ports link_up_out (output, 1), state_out (output, 3), err_count_out (output, 16) and word_count_out (output, 32), meaning link status, FSM state, errors and checked words.

Function
REQ-014 SHALL implement states IDLE=0, WAIT_LOCK=1, RESET_GT=2, WAIT_DONE=3, ALIGN=4, DATA=5, FAIL=6, and drive state_out with the current encoding.
REQ-015 SHALL, in IDLE, move to WAIT_LOCK when start_in=1, and clear err_count, word_count and the timeout counter on that transition.
REQ-016 SHALL, in WAIT_LOCK, move to RESET_GT on qplllock_in=1, or to FAIL after LOCK_TIMEOUT cycles without lock.
REQ-017 SHALL, in RESET_GT, hold gttxreset_out=gtrxreset_out=1 for exactly RST_CYCLES cycles, then move to WAIT_DONE.
REQ-018 SHALL hold txuserrdy_out=rxuserrdy_out=1 in WAIT_DONE, ALIGN and DATA, and 0 otherwise.
REQ-019 SHALL, in WAIT_DONE, move to ALIGN when txresetdone_in and rxresetdone_in are both 1 in the same cycle, or to FAIL after LOCK_TIMEOUT cycles (counter restarted on entry).
REQ-020 SHALL, in ALIGN, register txdata_out=32'h000000BC and txcharisk_out=4'b0001 (K28.5 in byte 0).
REQ-021 SHALL, in ALIGN, count a received comma as rxdata_in=32'h000000BC with rxcharisk_in=4'b0001; any other word resets the consecutive count to 0.
REQ-022 SHALL, in ALIGN, move to DATA when the consecutive count reaches ALIGN_WORDS, or to FAIL after LOCK_TIMEOUT cycles.
REQ-023 SHALL, in DATA, transmit an incrementing 32-bit counter starting at 0 on the first DATA cycle, with txcharisk_out=0, wrapping from FFFFFFFF to 0.
REQ-024 SHALL, in DATA, ignore received words with rxcharisk_in != 0 (no compare, no count).
REQ-025 SHALL, in DATA, use the first received word with rxcharisk_in=0 only to seed expected = rxdata_in+1; it is neither counted nor compared.
REQ-026 SHALL, for each later received word with rxcharisk_in=0, increment word_count_out (wrapping) and compare against expected.
REQ-027 SHALL, on a mismatch, increment err_count_out (saturating at FFFF) and resynchronise expected = rxdata_in+1.
REQ-028 SHALL, on a match, set expected = expected+1 (mod 2^32).
REQ-029 SHALL move from DATA to FAIL in the cycle after err_count_out reaches ERR_LIMIT.
REQ-030 SHALL move to FAIL from RESET_GT, WAIT_DONE, ALIGN or DATA whenever qplllock_in=0; this has priority over all other transitions.
REQ-031 SHALL drive link_up_out=1 only in DATA, with 1 cycle of latency from the state change (registered).
REQ-032 SHALL, in FAIL, hold GT resets at 0, userrdy at 0, link_up at 0 and counters frozen, and re-enter WAIT_LOCK (counters cleared) when start_in=1.
REQ-033 SHALL drive txdata_out=0 and txcharisk_out=0 in every state except ALIGN and DATA.
REQ-034 SHALL ignore start_in outside IDLE and FAIL.

Reset
REQ-035 SHALL, when soft_reset_in=1 at a clock edge, force state IDLE and set all outputs and counters to 0, including mid-RESET_GT, which truncates the GT reset pulse.
REQ-036 SHALL give soft_reset_in priority over every transition, including start_in in the same cycle.

Verification
REQ-037 SHALL cover: start_in=1 with qplllock_in=1 and both resetdone raised 5 cycles after userrdy -> GT resets high for exactly 16 cycles, ALIGN entered, 64 looped commas -> DATA, link_up_out=1, err_count_out=0.
REQ-038 SHALL cover: qplllock_in held 0 -> FAIL after exactly 100000 cycles in WAIT_LOCK, with state_out=6.
REQ-039 SHALL cover: in DATA, rxdata_in corrupted for 3 isolated words -> err_count_out=3, with word_count_out still incrementing for every non-K word after the seed.
REQ-040 SHALL cover: in ALIGN, a non-comma word injected at consecutive count 63 -> count resets to 0, and DATA is entered only after 64 more commas.
REQ-041 SHALL cover: qplllock_in dropped during DATA in the same cycle as an error -> FAIL next cycle, link_up_out=0, and err_count_out frozen.
REQ-042 SHALL cover: soft_reset_in=1 during RESET_GT -> gttxreset_out=0 and state_out=0 on the next edge; start_in then restarts the full sequence.
